// File: rtl/spw_rx_oversampled_if.sv
// N-char read port between the oversampled SpaceWire receiver FIFO and its consumer.
interface spw_rx_oversampled_if;
  logic [8:0] rx_data_flag;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data_flag, output rx_valid, input rx_ready);
  modport slave  (input rx_data_flag, input rx_valid, output rx_ready);
endinterface

// File: rtl/spw_rx_oversampled.sv
// SpaceWire receiver that oversamples Data/Strobe with the system clock,
// decodes characters, checks link errors and buffers N-chars in a FIFO.
module spw_rx_oversampled #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int DISC_CYCLES = 85
) (
  input  logic                        rx_clk,
  input  logic                        rx_reset,
  input  logic                        rx_din,
  input  logic                        rx_sin,
  input  logic                        rx_enable,
  output logic                        rx_got_bit,
  output logic                        rx_got_null,
  output logic                        rx_got_fct,
  output logic                        rx_tick_out,
  output logic [7:0]                  rx_time_out,
  output logic                        rx_error_parity,
  output logic                        rx_error_esc,
  output logic                        rx_error_ds,
  output logic                        rx_error_disc,
  output logic                        rx_overflow,
  spw_rx_oversampled_if.master        rx_port
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int DCW = $clog2(DISC_CYCLES + 1);
  localparam logic [7:0] NULL_PATTERN = 8'b0111_0100;

  typedef enum logic [1:0] {HUNT, PARITY, FLAG, PAYLOAD} rx_state_t;

  logic [SYNC_STAGES-1:0] d_sync, s_sync;
  logic                   d_prev, s_prev;
  logic                   d_now, s_now, d_chg, s_chg;
  logic                   new_bit, ds_fault;
  logic                   bit_valid, bit_val;

  logic [DCW-1:0]         disc_cnt;
  logic                   disc_armed, disc_fire;

  rx_state_t              state, state_n;
  logic [7:0]             hunt_sr, hunt_sr_n, hunt_shift;
  logic                   par_bit, par_bit_n;
  logic                   pay_par, pay_par_n;
  logic                   is_data, is_data_n;
  logic                   esc_pend, esc_pend_n;
  logic [2:0]             cnt, cnt_n;
  logic [7:0]             shift, shift_n;
  logic [7:0]             byte_n;
  logic [1:0]             code;

  logic                   null_p, fct_p, tick_p, wr_p, perr_p, eerr_p;
  logic [8:0]             wr_d;
  logic [7:0]             time_n;
  logic                   wr_req;
  logic [8:0]             wr_data;

  logic [8:0]             fifo_mem [FIFO_DEPTH];
  logic [AW:0]            wr_ptr, rd_ptr;
  logic                   fifo_full, fifo_empty, do_rd, do_wr;

  assign d_now    = d_sync[SYNC_STAGES-1];
  assign s_now    = s_sync[SYNC_STAGES-1];
  assign d_chg    = d_now ^ d_prev;
  assign s_chg    = s_now ^ s_prev;
  assign new_bit  = rx_enable && (d_chg ^ s_chg);
  assign ds_fault = rx_enable && d_chg && s_chg;

  // Bring the asynchronous D/S pads into the clock domain and keep the previous sample for edge detection.
  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      d_sync <= '0;
      s_sync <= '0;
      d_prev <= 1'b0;
      s_prev <= 1'b0;
    end else begin
      d_sync <= {d_sync[SYNC_STAGES-2:0], rx_din};
      s_sync <= {s_sync[SYNC_STAGES-2:0], rx_sin};
      d_prev <= d_now;
      s_prev <= s_now;
    end
  end

  // Register each recovered bit so the decoder sees one clean bit strobe.
  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      bit_valid <= 1'b0;
      bit_val   <= 1'b0;
    end else begin
      bit_valid <= new_bit;
      bit_val   <= d_now;
    end
  end

  assign rx_got_bit = bit_valid;

  // Disconnect timer: armed by the first bit, restarted by every bit, saturates at the limit.
  always_ff @(posedge rx_clk) begin
    if (rx_reset || !rx_enable) begin
      disc_cnt   <= '0;
      disc_armed <= 1'b0;
    end else if (new_bit) begin
      disc_cnt   <= '0;
      disc_armed <= 1'b1;
    end else if (disc_armed && (disc_cnt != DCW'(DISC_CYCLES))) begin
      disc_cnt <= disc_cnt + DCW'(1);
    end
  end

  assign disc_fire  = rx_enable && disc_armed && !new_bit && (disc_cnt == DCW'(DISC_CYCLES - 1));
  assign hunt_shift = {hunt_sr[6:0], bit_val};

  // Decoder state register and its datapath.
  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      state    <= HUNT;
      hunt_sr  <= 8'hFF;
      par_bit  <= 1'b0;
      pay_par  <= 1'b0;
      is_data  <= 1'b0;
      esc_pend <= 1'b0;
      cnt      <= 3'd0;
      shift    <= 8'h00;
    end else begin
      state    <= state_n;
      hunt_sr  <= hunt_sr_n;
      par_bit  <= par_bit_n;
      pay_par  <= pay_par_n;
      is_data  <= is_data_n;
      esc_pend <= esc_pend_n;
      cnt      <= cnt_n;
      shift    <= shift_n;
    end
  end

  // Character decoding: hunt for NULL, then parity/flag/payload per character.
  always_comb begin
    state_n    = state;
    hunt_sr_n  = hunt_sr;
    par_bit_n  = par_bit;
    pay_par_n  = pay_par;
    is_data_n  = is_data;
    esc_pend_n = esc_pend;
    cnt_n      = cnt;
    shift_n    = shift;
    byte_n     = 8'h00;
    code       = 2'b00;
    null_p     = 1'b0;
    fct_p      = 1'b0;
    tick_p     = 1'b0;
    wr_p       = 1'b0;
    wr_d       = 9'h000;
    perr_p     = 1'b0;
    eerr_p     = 1'b0;
    time_n     = rx_time_out;

    if (!rx_enable || ds_fault || disc_fire) begin
      state_n   = HUNT;
      hunt_sr_n = 8'hFF;
    end else if (bit_valid) begin
      case (state)
        HUNT: begin
          hunt_sr_n = hunt_shift;
          if (hunt_shift == NULL_PATTERN) begin
            null_p     = 1'b1;
            esc_pend_n = 1'b0;
            pay_par_n  = 1'b0;
            hunt_sr_n  = 8'hFF;
            state_n    = PARITY;
          end
        end
        PARITY: begin
          par_bit_n = bit_val;
          state_n   = FLAG;
        end
        FLAG: begin
          if ((pay_par ^ par_bit ^ bit_val) == 1'b1) begin
            is_data_n = !bit_val;
            pay_par_n = 1'b0;
            cnt_n     = 3'd0;
            shift_n   = 8'h00;
            state_n   = PAYLOAD;
          end else begin
            perr_p  = 1'b1;
            state_n = HUNT;
          end
        end
        PAYLOAD: begin
          pay_par_n = pay_par ^ bit_val;
          cnt_n     = cnt + 3'd1;
          if (is_data) begin
            byte_n  = {bit_val, shift[7:1]};
            shift_n = byte_n;
            if (cnt == 3'd7) begin
              state_n = PARITY;
              if (esc_pend) begin
                tick_p     = 1'b1;
                time_n     = byte_n;
                esc_pend_n = 1'b0;
              end else begin
                wr_p = 1'b1;
                wr_d = {1'b0, byte_n};
              end
            end
          end else begin
            code    = {shift[0], bit_val};
            shift_n = {6'd0, shift[0], bit_val};
            if (cnt == 3'd1) begin
              state_n = PARITY;
              if (code == 2'b00) begin
                if (esc_pend) begin
                  null_p     = 1'b1;
                  esc_pend_n = 1'b0;
                end else begin
                  fct_p = 1'b1;
                end
              end else if (esc_pend) begin
                eerr_p     = 1'b1;
                esc_pend_n = 1'b0;
                state_n    = HUNT;
              end else if (code == 2'b01) begin
                wr_p = 1'b1;
                wr_d = 9'h100;
              end else if (code == 2'b10) begin
                wr_p = 1'b1;
                wr_d = 9'h101;
              end else begin
                esc_pend_n = 1'b1;
              end
            end
          end
        end
        default: begin
          state_n   = HUNT;
          hunt_sr_n = 8'hFF;
        end
      endcase
    end
  end

  // Decode pulses, time-code value, pending FIFO write and sticky error flags.
  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      rx_got_null     <= 1'b0;
      rx_got_fct      <= 1'b0;
      rx_tick_out     <= 1'b0;
      rx_time_out     <= 8'h00;
      wr_req          <= 1'b0;
      wr_data         <= 9'h000;
      rx_error_parity <= 1'b0;
      rx_error_esc    <= 1'b0;
      rx_error_ds     <= 1'b0;
      rx_error_disc   <= 1'b0;
      rx_overflow     <= 1'b0;
    end else begin
      rx_got_null     <= null_p;
      rx_got_fct      <= fct_p;
      rx_tick_out     <= tick_p;
      rx_time_out     <= time_n;
      wr_req          <= wr_p;
      wr_data         <= wr_d;
      rx_error_parity <= rx_error_parity | perr_p;
      rx_error_esc    <= rx_error_esc | eerr_p;
      rx_error_ds     <= rx_error_ds | ds_fault;
      rx_error_disc   <= rx_error_disc | disc_fire;
      rx_overflow     <= rx_overflow | (wr_req && fifo_full && !do_rd);
    end
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd      = !fifo_empty && rx_port.rx_ready;
  assign do_wr      = wr_req && (!fifo_full || do_rd);

  // FIFO pointers; a write into a full FIFO only proceeds when a read frees a slot the same cycle.
  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // FIFO storage needs no reset since the empty flag masks stale entries.
  always_ff @(posedge rx_clk) begin
    if (do_wr) fifo_mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign rx_port.rx_valid     = !fifo_empty;
  assign rx_port.rx_data_flag = fifo_empty ? 9'h000 : fifo_mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_spw_rx_oversampled.sv
// Self-checking bench for spw_rx_oversampled: DS-encoded character streams
// decoded by a bit-list reference model and compared with the receiver outputs.
module tb_spw_rx_oversampled;

  localparam int SYNC_STAGES = 2;
  localparam int FIFO_DEPTH  = 8;
  localparam int DISC_CYCLES = 85;

  logic       rx_clk = 1'b0;
  logic       rx_reset, rx_din, rx_sin, rx_enable;
  logic       rx_got_bit, rx_got_null, rx_got_fct, rx_tick_out;
  logic [7:0] rx_time_out;
  logic       rx_error_parity, rx_error_esc, rx_error_ds, rx_error_disc, rx_overflow;

  spw_rx_oversampled_if rx_port ();

  spw_rx_oversampled #(
    .SYNC_STAGES(SYNC_STAGES),
    .FIFO_DEPTH (FIFO_DEPTH),
    .DISC_CYCLES(DISC_CYCLES)
  ) dut (
    .rx_clk         (rx_clk),
    .rx_reset       (rx_reset),
    .rx_din         (rx_din),
    .rx_sin         (rx_sin),
    .rx_enable      (rx_enable),
    .rx_got_bit     (rx_got_bit),
    .rx_got_null    (rx_got_null),
    .rx_got_fct     (rx_got_fct),
    .rx_tick_out    (rx_tick_out),
    .rx_time_out    (rx_time_out),
    .rx_error_parity(rx_error_parity),
    .rx_error_esc   (rx_error_esc),
    .rx_error_ds    (rx_error_ds),
    .rx_error_disc  (rx_error_disc),
    .rx_overflow    (rx_overflow),
    .rx_port        (rx_port)
  );

  always #5 rx_clk = ~rx_clk;

  int         cmp_cnt = 0;
  int         err_cnt = 0;

  int         cnt_bit, cnt_null, cnt_fct, cnt_tick;
  logic [8:0] got_q[$];

  int         period;
  bit         tx_d, tx_s, tx_ppar;
  bit         stream[$];

  int         exp_null, exp_fct, exp_tick;
  logic [7:0] exp_time;
  logic [8:0] exp_q[$];
  bit         exp_perr, exp_eerr;

  // Observe pulses and FIFO pops half a cycle away from the active edge.
  always @(negedge rx_clk) begin
    if (rx_reset) begin
      cnt_bit  = 0;
      cnt_null = 0;
      cnt_fct  = 0;
      cnt_tick = 0;
      got_q.delete();
    end else begin
      if (rx_got_bit)  cnt_bit++;
      if (rx_got_null) cnt_null++;
      if (rx_got_fct)  cnt_fct++;
      if (rx_tick_out) cnt_tick++;
      if (rx_port.rx_valid && rx_port.rx_ready) got_q.push_back(rx_port.rx_data_flag);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    cmp_cnt++;
    assert (observed === expected)
    else begin
      err_cnt++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic resetDut();
    rx_reset = 1'b1;
    rx_din = 1'b0;
    rx_sin = 1'b0;
    rx_enable = 1'b1;
    rx_port.rx_ready = 1'b1;
    tx_d = 1'b0;
    tx_s = 1'b0;
    tx_ppar = 1'b0;
    stream.delete();
    repeat (3) @(posedge rx_clk);
    #1 rx_reset = 1'b0;
    @(posedge rx_clk);
    #1;
  endtask

  // Data-strobe encode one bit and hold it for the current bit period.
  task automatic applyStimulus(input bit b);
    if (b != tx_d) tx_d = b;
    else           tx_s = ~tx_s;
    rx_din = tx_d;
    rx_sin = tx_s;
    stream.push_back(b);
    repeat (period) @(posedge rx_clk);
    #1;
  endtask

  // Control payload is {first, second} in payload[1:0]; data goes LSB first.
  task automatic sendChar(input bit flag, input logic [7:0] payload, input bit corrupt);
    bit pp;
    applyStimulus(1'b1 ^ tx_ppar ^ flag ^ corrupt);
    applyStimulus(flag);
    pp = 1'b0;
    if (flag) begin
      applyStimulus(payload[1]);
      applyStimulus(payload[0]);
      pp = payload[1] ^ payload[0];
    end else begin
      for (int k = 0; k < 8; k++) begin
        applyStimulus(payload[k]);
        pp ^= payload[k];
      end
    end
    tx_ppar = pp;
  endtask

  task automatic sendNull();
    sendChar(1'b1, 8'h03, 1'b0);
    sendChar(1'b1, 8'h00, 1'b0);
  endtask

  // Reference decoder: walks the transmitted bit list character by character.
  task automatic modelDecode();
    int         i, hunt_from, len;
    bit         hunting, esc, ppar, p, f, pp;
    logic [7:0] val, w;
    logic [1:0] code;
    exp_null = 0; exp_fct = 0; exp_tick = 0; exp_time = 8'h00;
    exp_q.delete(); exp_perr = 1'b0; exp_eerr = 1'b0;
    i = 0; hunt_from = 0; hunting = 1'b1; esc = 1'b0; ppar = 1'b0;
    while (i < stream.size()) begin
      if (hunting) begin
        if (i - hunt_from >= 7) begin
          w = 8'h00;
          for (int k = 7; k >= 0; k--) w = {w[6:0], stream[i-k]};
          if (w == 8'b0111_0100) begin
            exp_null++;
            hunting = 1'b0;
            esc = 1'b0;
            ppar = 1'b0;
          end
        end
        i++;
      end else begin
        if (i + 1 >= stream.size()) break;
        p = stream[i];
        f = stream[i+1];
        if ((ppar ^ p ^ f) != 1'b1) begin
          exp_perr = 1'b1;
          hunting = 1'b1;
          i += 2;
          hunt_from = i;
          continue;
        end
        len = f ? 2 : 8;
        if (i + 2 + len > stream.size()) break;
        val = 8'h00;
        pp = 1'b0;
        for (int k = 0; k < len; k++) begin
          val[k] = stream[i+2+k];
          pp ^= stream[i+2+k];
        end
        i += 2 + len;
        ppar = pp;
        if (!f) begin
          if (esc) begin
            exp_tick++;
            exp_time = val;
            esc = 1'b0;
          end else begin
            exp_q.push_back({1'b0, val});
          end
        end else begin
          code = {val[0], val[1]};
          if (code == 2'b00) begin
            if (esc) begin
              exp_null++;
              esc = 1'b0;
            end else begin
              exp_fct++;
            end
          end else if (esc) begin
            exp_eerr = 1'b1;
            hunting = 1'b1;
            hunt_from = i;
            esc = 1'b0;
          end else if (code == 2'b01) exp_q.push_back(9'h100);
          else if (code == 2'b10) exp_q.push_back(9'h101);
          else esc = 1'b1;
        end
      end
    end
  endtask

  task automatic finishScenario(input string name);
    repeat (24) @(posedge rx_clk);
    #1;
    modelDecode();
    checkOutput({name, ".bits"}, cnt_bit, stream.size());
    checkOutput({name, ".null"}, cnt_null, exp_null);
    checkOutput({name, ".fct"}, cnt_fct, exp_fct);
    checkOutput({name, ".tick"}, cnt_tick, exp_tick);
    checkOutput({name, ".time"}, rx_time_out, exp_time);
    checkOutput({name, ".fifo_count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      checkOutput($sformatf("%s.fifo%0d", name, k),
                  (k < got_q.size()) ? 32'(got_q[k]) : 32'hFFFF_FFFF, 32'(exp_q[k]));
    checkOutput({name, ".err_parity"}, rx_error_parity, exp_perr);
    checkOutput({name, ".err_esc"}, rx_error_esc, exp_eerr);
    checkOutput({name, ".err_ds"}, rx_error_ds, 1'b0);
    checkOutput({name, ".err_disc"}, rx_error_disc, 1'b0);
    checkOutput({name, ".overflow"}, rx_overflow, 1'b0);
    checkOutput({name, ".valid_idle"}, rx_port.rx_valid, 1'b0);
  endtask

  // Directed scenarios followed by randomized character mixes.
  initial begin
    int kind;
    bit corrupt;
    logic [8:0] head;
    $display("[TB] start");
    period = 4;
    resetDut();
    checkOutput("rst.got_bit", rx_got_bit, 1'b0);
    checkOutput("rst.got_null", rx_got_null, 1'b0);
    checkOutput("rst.got_fct", rx_got_fct, 1'b0);
    checkOutput("rst.tick", rx_tick_out, 1'b0);
    checkOutput("rst.time", rx_time_out, 8'h00);
    checkOutput("rst.valid", rx_port.rx_valid, 1'b0);
    checkOutput("rst.data_flag", rx_port.rx_data_flag, 9'h000);
    checkOutput("rst.errors", {rx_error_parity, rx_error_esc, rx_error_ds, rx_error_disc, rx_overflow}, 5'b0);

    sendNull(); sendNull(); sendNull();
    finishScenario("nulls");
    checkOutput("nulls.direct", cnt_null, 3);

    resetDut();
    sendNull(); sendChar(1'b1, 8'h00, 1'b0); sendChar(1'b1, 8'h00, 1'b0);
    finishScenario("fct");
    checkOutput("fct.direct", cnt_fct, 2);

    resetDut();
    sendNull(); sendChar(1'b0, 8'hA5, 1'b0); sendChar(1'b1, 8'h01, 1'b0); sendChar(1'b1, 8'h02, 1'b0);
    finishScenario("data");
    checkOutput("data.direct0", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hFFFF_FFFF, 9'h0A5);

    resetDut();
    sendNull(); sendChar(1'b1, 8'h03, 1'b0); sendChar(1'b0, 8'h3F, 1'b0);
    sendNull(); sendChar(1'b1, 8'h03, 1'b0); sendChar(1'b1, 8'h01, 1'b0);
    finishScenario("tcode");
    checkOutput("tcode.direct_time", rx_time_out, 8'h3F);
    checkOutput("tcode.direct_esc", rx_error_esc, 1'b1);

    resetDut();
    sendNull(); sendChar(1'b0, 8'h01, 1'b1);
    sendChar(1'b0, 8'h55, 1'b0); sendChar(1'b0, 8'h22, 1'b0);
    sendNull(); sendNull(); sendChar(1'b0, 8'h77, 1'b0);
    finishScenario("parity");
    checkOutput("parity.direct_err", rx_error_parity, 1'b1);
    checkOutput("parity.direct_last", (got_q.size() > 0) ? 32'(got_q[got_q.size()-1]) : 32'hFFFF_FFFF, 9'h077);

    resetDut();
    rx_port.rx_ready = 1'b0;
    sendNull();
    for (int k = 0; k <= FIFO_DEPTH; k++) sendChar(1'b0, 8'(k), 1'b0);
    repeat (20) @(posedge rx_clk);
    #1;
    checkOutput("ovf.flag", rx_overflow, 1'b1);
    checkOutput("ovf.valid", rx_port.rx_valid, 1'b1);
    head = rx_port.rx_data_flag;
    repeat (3) @(posedge rx_clk);
    #1;
    checkOutput("ovf.head_stable", rx_port.rx_data_flag, 9'h000);
    checkOutput("ovf.head_held", rx_port.rx_data_flag, head);
    rx_port.rx_ready = 1'b1;
    repeat (20) @(posedge rx_clk);
    #1;
    checkOutput("ovf.read_count", got_q.size(), FIFO_DEPTH);
    for (int k = 0; k < FIFO_DEPTH; k++)
      checkOutput($sformatf("ovf.read%0d", k), (k < got_q.size()) ? 32'(got_q[k]) : 32'hFFFF_FFFF, k);
    checkOutput("disc.before", rx_error_disc, 1'b0);
    repeat (70) @(posedge rx_clk);
    #1;
    checkOutput("disc.after", rx_error_disc, 1'b1);
    checkOutput("ds.before", rx_error_ds, 1'b0);
    tx_d = ~tx_d;
    tx_s = ~tx_s;
    rx_din = tx_d;
    rx_sin = tx_s;
    repeat (10) @(posedge rx_clk);
    #1;
    checkOutput("ds.after", rx_error_ds, 1'b1);

    resetDut();
    rx_enable = 1'b0;
    sendNull(); sendNull();
    repeat (20) @(posedge rx_clk);
    #1;
    checkOutput("en.off_bits", cnt_bit, 0);
    checkOutput("en.off_null", cnt_null, 0);
    rx_enable = 1'b1;
    stream.delete();
    sendNull(); sendChar(1'b0, 8'h5A, 1'b0);
    finishScenario("en");

    for (int r = 0; r < 4; r++) begin
      resetDut();
      period = int'($urandom_range(2, 6));
      sendNull();
      for (int c = 0; c < 14; c++) begin
        kind = int'($urandom_range(0, 9));
        corrupt = ($urandom_range(0, 11) == 0);
        case (kind)
          4: sendChar(1'b1, 8'h01, corrupt);
          5: sendChar(1'b1, 8'h02, corrupt);
          6: sendChar(1'b1, 8'h00, corrupt);
          7: sendNull();
          8: begin
            sendChar(1'b1, 8'h03, corrupt);
            sendChar(1'b0, 8'($urandom), 1'b0);
          end
          9: begin
            if ($urandom_range(0, 3) == 0) begin
              sendChar(1'b1, 8'h03, 1'b0);
              sendChar(1'b1, 8'h01, 1'b0);
            end else begin
              sendChar(1'b0, 8'($urandom), corrupt);
            end
          end
          default: sendChar(1'b0, 8'($urandom), corrupt);
        endcase
      end
      finishScenario($sformatf("rand%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/spw_rx_oversampled.md
# spw_rx_oversampled

Parametrised SpaceWire receiver that oversamples the Data/Strobe pair with the system clock instead of using a recovered D^S clock. It decodes NULL, FCT, EOP, EEP, data and time-code characters, checks parity, escape sequences, simultaneous D/S transitions and disconnect timeout, and buffers N-chars in an internal FIFO with a valid/ready read port. It sits between the LVDS input pads and the link-interface FSM / host RX buffer.

## Interface
- SYNC_STAGES, 2: synchroniser flops on rx_din/rx_sin (≥2).
- FIFO_DEPTH, 8: N-char FIFO entries (power of two, ≥2).
- DISC_CYCLES, 85: rx_clk cycles without a new bit before disconnect (≥4).
- rx_clk  in  1  system clock; all logic on rising edge.
- rx_reset  in  1  synchronous, active-high reset.
- rx_din  in  1  asynchronous SpaceWire Data.
- rx_sin  in  1  asynchronous SpaceWire Strobe.
- rx_enable  in  1  0 forces HUNT and clears the disconnect counter.
- rx_got_bit  out  1  pulse: a bit was sampled.
- rx_got_null  out  1  pulse: NULL decoded.
- rx_got_fct  out  1  pulse: FCT (not escaped) decoded.
- rx_tick_out  out  1  pulse: time-code decoded.
- rx_time_out  out  8  last time-code value.
- rx_data_flag  out  9  FIFO head: {0,d[7:0]} data, 9'h100 EOP, 9'h101 EEP.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  pop FIFO head when rx_valid.
- rx_error_parity / rx_error_esc / rx_error_ds / rx_error_disc / rx_overflow  out  1 each  sticky error flags.

## Operation
- Reset: all outputs 0, rx_time_out 0, FIFO empty, state HUNT, sticky flags cleared. Sticky flags clear only on rx_reset.
- Bit detection: synchronised d,s registered as prev. Exactly one of d,s changed → new bit = synced d, rx_got_bit pulse. Both changed in one cycle → rx_error_ds, state HUNT.
- Bit order: parity, flag, then payload LSB first. Control payload {a,b} in arrival order: 00 FCT, 01 EOP, 10 EEP, 11 ESC. Data payload 8 bits.
- Parity: odd over previous char's payload bits + current parity + current flag. Mismatch → rx_error_parity, HUNT.
- States: HUNT, PARITY, FLAG, PAYLOAD (2 or 8 bits by flag).
- HUNT: 8-bit arrival-order shift register; match 0,1,1,1,0,1,0,0 → rx_got_null, ESC flag clear, parity reference = FCT payload, go PARITY. Parity of the first char is not checked.
- Character handling, end of payload: data, no ESC pending → FIFO write {0,d}. Data, ESC pending → time-code, rx_time_out=d, rx_tick_out. FCT, ESC pending → rx_got_null; otherwise rx_got_fct. EOP/EEP → FIFO write 9'h100/9'h101. ESC sets ESC pending. ESC pending + ESC/EOP/EEP → rx_error_esc, HUNT, no write.
- FIFO full on write → char dropped, rx_overflow. Write and read in the same cycle when full → both proceed. Read when empty → ignored.
- Disconnect: counter resets on every bit. Counting starts after the first bit following reset/enable. Reaching DISC_CYCLES → rx_error_disc, HUNT. Counter holds until the next bit.
- Any error → HUNT. FIFO contents are kept. Decoding resumes on the next matched NULL.

## Timing
- Input to bit detect: SYNC_STAGES+1 cycles. Bit period must be ≥2 rx_clk periods.
- Decode pulses (got_null/fct/tick) assert 1 cycle after the last payload bit is registered, for 1 cycle.
- FIFO write occurs on the same cycle as the decode pulse would. rx_valid rises the next cycle. rx_data_flag is stable while rx_valid && !rx_ready.
- Error flags set on the cycle the fault is detected.
- rx_reset or rx_enable=0 mid-character: partial char discarded. No pulse issued.

## Test plan
- Reset, then 3 NULLs (bit period 4 cycles) → rx_got_null pulses 3×, no errors, rx_valid=0.
- NULL, FCT, FCT → rx_got_fct 2 pulses, no FIFO write.
- NULL, data 0xA5, EOP, EEP, with rx_ready=1 → reads 9'h0A5, 9'h100, 9'h101 in order.
- NULL, ESC, data 0x3F → rx_tick_out 1 pulse, rx_time_out=0x3F, FIFO empty. Then NULL, ESC, EOP → rx_error_esc.
- NULL, data 0x01 with parity bit inverted → rx_error_parity, no write. Then data chars ignored until a NULL; the next data char after that NULL is written.
- rx_ready=0, NULL plus FIFO_DEPTH+1 data chars 0..8 → rx_overflow, reads 0..7. Then D/S idle DISC_CYCLES → rx_error_disc. Then toggle D and S together → rx_error_ds.
